// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C requester arbiter and the
// byte-level I2C master it drives.
package i2c_arb_pkg;

  // Address and data widths shared with the I2C master engine.
  localparam int AW = 7;
  localparam int DW = 8;

  // Response status codes returned on rsp_err.
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit at or
// above ptr, wrapping around, as both a one-hot vector and a binary index.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx
);

  logic          found_s;
  logic [IW:0]   pos_s;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    win     = {NREQ{1'b0}};
    idx     = {IW{1'b0}};
    found_s = 1'b0;
    pos_s   = {(IW+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      pos_s = {1'b0, ptr} + (IW+1)'(k);
      if (pos_s >= (IW+1)'(NREQ)) begin
        pos_s = pos_s - (IW+1)'(NREQ);
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && req[pos_s[IW-1:0]]) begin
        found_s                = 1'b1;
        win[pos_s[IW-1:0]]     = 1'b1;
        idx                    = pos_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one byte-level I2C master between
// NREQ requesters: grants one requester, latches its fields, issues the
// transaction, supervises completion with a timeout and returns the result.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [7:0]        m_wdata,
  output logic              m_abort,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_nack,
  input  logic [7:0]        m_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_r;
  logic [IW-1:0]     ptr_r;
  logic [IW-1:0]     idx_r;
  logic [TW-1:0]     cnt_r;
  logic [NREQ-1:0]   gnt_r;
  logic [NREQ-1:0]   rsp_valid_r;
  logic [DW-1:0]     rsp_rdata_r;
  logic [1:0]        rsp_err_r;
  logic              m_start_r;
  logic              m_abort_r;
  logic [AW-1:0]     m_addr_r;
  logic              m_rw_r;
  logic [DW-1:0]     m_wdata_r;

  logic [NREQ-1:0]   pick_win_s;
  logic [IW-1:0]     pick_idx_s;
  logic [AW-1:0]     sel_addr_s;
  logic              sel_rw_s;
  logic [DW-1:0]     sel_wdata_s;
  logic [IW-1:0]     ptr_next_s;
  logic              tmo_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr_r),
    .win (pick_win_s),
    .idx (pick_idx_s)
  );

  // Route the winning requester's fields to the latch inputs.
  always_comb begin
    sel_addr_s  = {AW{1'b0}};
    sel_rw_s    = 1'b0;
    sel_wdata_s = {DW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (pick_win_s[i]) begin
        sel_addr_s  = req_addr[i*AW +: AW];
        sel_rw_s    = req_rw[i];
        sel_wdata_s = req_wdata[i*DW +: DW];
      end else begin
        sel_addr_s  = sel_addr_s;
      end
    end
  end

  // Next round-robin pointer (one past the current grant) and timeout detect.
  // cnt_r equals the number of cycles elapsed since m_start, so the abort
  // decision is made one cycle early to land m_abort exactly TIMEOUT after it.
  always_comb begin
    if (idx_r == IW'(NREQ-1)) begin
      ptr_next_s = {IW{1'b0}};
    end else begin
      ptr_next_s = idx_r + IW'(1);
    end
    tmo_s = (cnt_r >= TW'(TIMEOUT-1));
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {IW{1'b0}};
      idx_r       <= {IW{1'b0}};
      cnt_r       <= {TW{1'b0}};
      gnt_r       <= {NREQ{1'b0}};
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_rdata_r <= {DW{1'b0}};
      rsp_err_r   <= ERR_OK;
      m_start_r   <= 1'b0;
      m_abort_r   <= 1'b0;
      m_addr_r    <= {AW{1'b0}};
      m_rw_r      <= 1'b0;
      m_wdata_r   <= {DW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((|req) && !m_busy) begin
            gnt_r     <= pick_win_s;
            idx_r     <= pick_idx_s;
            m_addr_r  <= sel_addr_s;
            m_rw_r    <= sel_rw_s;
            m_wdata_r <= sel_wdata_s;
            m_start_r <= 1'b1;
            state_r   <= ST_ISSUE;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          m_start_r <= 1'b0;
          cnt_r     <= TW'(1);
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (m_done) begin
            rsp_valid_r <= gnt_r;
            rsp_err_r   <= m_nack ? ERR_NACK : ERR_OK;
            rsp_rdata_r <= (m_rw_r && !m_nack) ? m_rdata : {DW{1'b0}};
            state_r     <= ST_RESP;
          end else if (tmo_s) begin
            m_abort_r   <= 1'b1;
            rsp_valid_r <= gnt_r;
            rsp_err_r   <= ERR_TMO;
            rsp_rdata_r <= {DW{1'b0}};
            state_r     <= ST_RESP;
          end else begin
            cnt_r       <= cnt_r + TW'(1);
          end
        end
        ST_RESP: begin
          rsp_valid_r <= {NREQ{1'b0}};
          m_abort_r   <= 1'b0;
          gnt_r       <= {NREQ{1'b0}};
          ptr_r       <= ptr_next_s;
          state_r     <= ST_HOLD;
        end
        ST_HOLD: begin
          state_r <= ST_IDLE;
        end
        default: begin
          gnt_r       <= {NREQ{1'b0}};
          rsp_valid_r <= {NREQ{1'b0}};
          m_start_r   <= 1'b0;
          m_abort_r   <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign m_start   = m_start_r;
  assign m_addr    = m_addr_r;
  assign m_rw      = m_rw_r;
  assign m_wdata   = m_wdata_r;
  assign m_abort   = m_abort_r;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: the bench plays both the requesters
// and the I2C engine, stepping cycle by cycle with hand-computed expectations.
module tb_i2c_req_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 50;
  localparam int TW      = 6;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ-1:0]   req_rw;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_rdata;
  logic [1:0]        rsp_err;
  logic              m_start;
  logic [6:0]        m_addr;
  logic              m_rw;
  logic [7:0]        m_wdata;
  logic              m_abort;
  logic              m_busy;
  logic              m_done;
  logic              m_nack;
  logic [7:0]        m_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_rw      (m_rw),
    .m_wdata   (m_wdata),
    .m_abort   (m_abort),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_nack    (m_nack),
    .m_rdata   (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_g;

    rst_n = 1'b0; req = 4'b0000; req_addr = '0; req_rw = 4'b0000; req_wdata = '0;
    m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_m_start", 32'(m_start), 32'h0);
    chk("rst_m_abort", 32'(m_abort), 32'h0);
    chk("rst_rdata_err", 32'({rsp_rdata, rsp_err}), 32'h0);
    chk("rst_m_fields", 32'({m_addr, m_rw, m_wdata}), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single write from requester 2, done after 40 cycles.
    req[2] = 1'b1; req_addr[14 +: 7] = 7'h09; req_wdata[16 +: 8] = 8'hBB; req_rw[2] = 1'b0;
    tick();                                   // cycle S
    chk("wr_gnt", 32'(gnt), 32'h4);
    chk("wr_m_start", 32'(m_start), 32'h1);
    chk("wr_m_addr", 32'(m_addr), 32'h09);
    chk("wr_m_wdata", 32'(m_wdata), 32'hBB);
    chk("wr_m_rw", 32'(m_rw), 32'h0);
    m_busy = 1'b1;
    req_addr[14 +: 7] = 7'h7F; req_wdata[16 +: 8] = 8'h11;
    tick();                                   // S+1
    chk("wr_m_start_pulse", 32'(m_start), 32'h0);
    chk("wr_latched_addr", 32'(m_addr), 32'h09);
    chk("wr_latched_wdata", 32'(m_wdata), 32'hBB);
    repeat (39) tick();                       // S+40 = M
    chk("wr_no_abort", 32'(m_abort), 32'h0);
    m_done = 1'b1;
    tick();                                   // M+1
    m_done = 1'b0; m_busy = 1'b0; req[2] = 1'b0;
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("wr_rsp_err", 32'(rsp_err), 32'h0);
    chk("wr_gnt_held", 32'(gnt), 32'h4);
    tick();                                   // M+2
    chk("wr_rsp_once", 32'(rsp_valid), 32'h0);
    chk("wr_gnt_low", 32'(gnt), 32'h0);
    tick();                                   // M+3 idle, ptr = 3

    // Read from requester 0 answered with NACK.
    req[0] = 1'b1; req_rw[0] = 1'b1; req_addr[0 +: 7] = 7'h50;
    tick();
    chk("rdn_gnt", 32'(gnt), 32'h1);
    chk("rdn_m_rw", 32'(m_rw), 32'h1);
    chk("rdn_m_addr", 32'(m_addr), 32'h50);
    m_busy = 1'b1;
    repeat (5) tick();
    m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'h3C;
    tick();
    m_done = 1'b0; m_nack = 1'b0; m_busy = 1'b0; req[0] = 1'b0;
    chk("rdn_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rdn_rsp_err", 32'(rsp_err), 32'h1);
    chk("rdn_rsp_rdata", 32'(rsp_rdata), 32'h00);
    tick(); tick();

    // Clean read from requester 0 returning 0xA5.
    req[0] = 1'b1;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h1);
    m_busy = 1'b1;
    repeat (3) tick();
    m_done = 1'b1; m_rdata = 8'hA5;
    tick();
    m_done = 1'b0; m_busy = 1'b0; m_rdata = 8'h00; req[0] = 1'b0;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_rdata", 32'(rsp_rdata), 32'hA5);
    chk("rd_rsp_err", 32'(rsp_err), 32'h0);
    tick(); tick();                           // ptr = 1

    // Timeout on requester 1: engine never completes.
    req[1] = 1'b1; req_rw[1] = 1'b0;
    tick();                                   // S
    chk("tmo_gnt", 32'(gnt), 32'h2);
    chk("tmo_m_start", 32'(m_start), 32'h1);
    m_busy = 1'b1;
    repeat (TIMEOUT-1) tick();                // S+49
    chk("tmo_abort_early", 32'(m_abort), 32'h0);
    chk("tmo_rsp_early", 32'(rsp_valid), 32'h0);
    tick();                                   // S+50
    chk("tmo_abort", 32'(m_abort), 32'h1);
    chk("tmo_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("tmo_rsp_err", 32'(rsp_err), 32'h2);
    chk("tmo_rsp_rdata", 32'(rsp_rdata), 32'h00);
    req[1] = 1'b0; req[2] = 1'b1; req_rw[2] = 1'b1;
    tick();                                   // S+51
    chk("tmo_abort_pulse", 32'(m_abort), 32'h0);
    repeat (4) tick();                        // S+55, engine still busy
    chk("tmo_wait_busy", 32'(gnt), 32'h0);
    m_busy = 1'b0;
    tick();                                   // S' : issue to requester 2
    chk("col_gnt", 32'(gnt), 32'h4);
    chk("col_m_start", 32'(m_start), 32'h1);

    // Collision: m_done arrives in the cycle the timeout decision is made.
    m_busy = 1'b1;
    repeat (TIMEOUT-1) tick();                // S'+49
    chk("col_abort_before", 32'(m_abort), 32'h0);
    m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'h77;
    tick();                                   // S'+50
    m_done = 1'b0; m_nack = 1'b0; m_busy = 1'b0; req[2] = 1'b0;
    chk("col_abort", 32'(m_abort), 32'h0);
    chk("col_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("col_rsp_err", 32'(rsp_err), 32'h1);
    tick();
    chk("col_abort_after", 32'(m_abort), 32'h0);
    tick();                                   // idle, ptr = 3

    // Reset while waiting: outputs clear at once, ptr returns to 0.
    req[2] = 1'b1;
    tick();
    chk("rstw_gnt", 32'(gnt), 32'h4);
    m_busy = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0; m_busy = 1'b0; req = 4'b1010;
    #1;
    chk("rstw_gnt_clear", 32'(gnt), 32'h0);
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rstw_abort", 32'(m_abort), 32'h0);
    chk("rstw_rsp_err", 32'(rsp_err), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rstw_first_gnt", 32'(gnt), 32'h2);

    // Fairness: all four held high from a fresh reset.
    rst_n = 1'b0; req = 4'b0000;
    tick();
    rst_n = 1'b1; req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      chk("fair_gnt", 32'(gnt), 32'(exp_g));
      chk("fair_m_start", 32'(m_start), 32'h1);
      m_busy = 1'b1;
      repeat (3) tick();
      m_done = 1'b1;
      tick();                                 // M+1
      m_done = 1'b0; m_busy = 1'b0;
      chk("fair_rsp_valid", 32'(rsp_valid), 32'(exp_g));
      tick();                                 // M+2
      chk("fair_gap", 32'(gnt), 32'h0);
      tick();                                 // M+3
      chk("fair_no_early_issue", 32'(gnt), 32'h0);
      tick();                                 // M+4
    end
    req = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Round-robin arbiter and sequencer that shares one byte-level I2C master engine between `NREQ` on-chip requesters. It accepts single-byte read or write transactions, issues them to the engine one at a time, supervises completion with a timeout, and returns read data and status to the originating requester. It sits between the requester logic and the I2C master that drives `sda`/`scl`.

## Interface
- `NREQ`, default 4: number of requesters, 2 to 8.
- `TIMEOUT`, default 1023: maximum cycles to wait for `m_done` after `m_start`.
- `TW`, default 10: timeout counter width; must satisfy `TIMEOUT < 2**TW`.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NREQ  per-requester request. Held high until that requester's `rsp_valid`.
- `req_addr`  in  NREQ*7  7-bit slave address per requester, packed with requester i at `[7i+6:7i]`.
- `req_rw`  in  NREQ  1 = read, 0 = write.
- `req_wdata`  in  NREQ*8  write byte per requester.
- `gnt`  out  NREQ  one-hot grant, high for the whole transaction.
- `rsp_valid`  out  NREQ  one-cycle completion pulse to the granted requester.
- `rsp_rdata`  out  8  read byte, shared. Valid only with `rsp_valid`.
- `rsp_err`  out  2  shared status: 00 ok, 01 address/data NACK, 10 timeout.
- `m_start`  out  1  one-cycle transaction start to the engine.
- `m_addr`  out  7  address to the engine, registered.
- `m_rw`  out  1  direction to the engine, registered.
- `m_wdata`  out  8  write byte to the engine, registered.
- `m_abort`  out  1  one-cycle abort, issued on timeout.
- `m_busy`  in  1  engine is mid-transaction.
- `m_done`  in  1  one-cycle completion pulse from the engine.
- `m_nack`  in  1  NACK flag. Valid with `m_done`.
- `m_rdata`  in  8  read byte. Valid with `m_done`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, HOLD.
- IDLE → ISSUE when any `req` bit is high and `m_busy` is 0.
  - The winner is the first set bit searching upward from `ptr`, wrapping.
  - `gnt`, `m_addr`, `m_rw` and `m_wdata` are registered from the winner. The winner's fields are latched, so later changes on the `req_*` inputs are ignored.
- ISSUE → WAIT unconditionally. `m_start` is high only in ISSUE. The timeout counter clears.
- WAIT:
  - The counter increments each cycle.
  - On `m_done`: capture `m_rdata`; `rsp_err` = 01 if `m_nack`, else 00; go to RESP.
  - If the counter reaches `TIMEOUT` without `m_done`: pulse `m_abort`; `rsp_err` = 10; `rsp_rdata` = 0; go to RESP.
  - If `m_done` and the timeout occur in the same cycle, `m_done` wins and there is no abort.
- RESP → HOLD. `rsp_valid[g]` = 1 for one cycle. `ptr` is set to g+1 mod `NREQ`.
- HOLD → IDLE. `gnt` = 0. This is a one-cycle gap so the requester can drop `req`. A `req` still high in IDLE is a new transaction.
- A requester dropping `req` mid-transaction does not cancel it; the transaction completes and its response is still pulsed.
- A write with NACK reports 01, and `rsp_rdata` = 0.
- After an abort, IDLE waits for `m_busy` = 0 before issuing again.

## Timing
- Reset values:
  - state = IDLE, `ptr` = 0.
  - `gnt`, `rsp_valid`, `m_start` and `m_abort` all 0.
  - `rsp_rdata`, `rsp_err`, `m_addr`, `m_rw` and `m_wdata` all 0.
- Reset asserted mid-transaction: all outputs are forced to reset values immediately, with no response and no abort. The engine is expected to be reset by the same `rst_n`.
- Latency:
  - `req` high at cycle 0 in IDLE with the engine idle: `gnt` and `m_start` are high at cycle 1.
  - `m_done` at cycle M: `rsp_valid` at M+1, `gnt` low at M+2, next issue no earlier than M+3.
- Back-to-back throughput: one transaction per (engine time + 4) cycles.
- Timeout: `m_abort` fires `TIMEOUT` cycles after the cycle in which `m_start` is high.
- `m_done` outside WAIT is ignored.

## Structure
- Shared package `i2c_arb_pkg`:
  - state enum encoding (3 bits);
  - error codes `ERR_OK`, `ERR_NACK`, `ERR_TMO`;
  - the address width (7) and data width (8) constants shared with the I2C master.
- Sub-module `rr_pick`: combinational round-robin one-hot picker with inputs `req` and `ptr`, outputs one-hot `win` and binary `idx`, parameterised by `NREQ`.
- Top level holds the FSM, the field latch, the timeout counter and the response registers.

## Test plan
- Single write: requester 2 sends addr 0x09, wdata 0xBB, rw 0; engine gives `m_done` after 40 cycles with `m_nack` 0 → `m_start` one cycle with `m_addr` 0x09, `m_wdata` 0xBB; `rsp_valid[2]` pulses once with `rsp_err` 00.
- Read with NACK: requester 0 reads; engine returns `m_nack` 1 → `rsp_err` 01, `rsp_rdata` 0x00. Then a clean read returning 0xA5 → `rsp_rdata` 0xA5, `rsp_err` 00.
- Fairness: all four `req` held high continuously → grant order 0,1,2,3,0. No requester is granted twice before the others.
- Timeout: engine never asserts `m_done` → `m_abort` exactly `TIMEOUT` cycles after `m_start`, `rsp_err` 10. The next issue waits for `m_busy` low.
- Collision: `m_done` and timeout in the same cycle → `rsp_err` reflects `m_nack`, and `m_abort` stays 0.
- Reset in WAIT: `rst_n` low → `gnt` 0 and `rsp_valid` 0 immediately. After release, the first grant is to the lowest requester index with `req` high, since `ptr` = 0.
